instr_readback_checker: RTL and testbench
=========================================

# instr_readback_checker

Read-side sequencer for the 32-entry instruction register. On a start command it walks a programmable window of register entries by driving `read_pointer`. For each entry it captures `instruction_word`, recomputes the expected result from opcode and operands, and flags any disagreement with the stored `rezultat`. Each checked entry is presented downstream on a valid/ready stream, and the block keeps a per-run error count.

## Interface
- `NUM_ENTRIES`, 32: register depth; equals 2**$bits(address_t).
- `CNT_W`, 6: width of `count` and `error_count`.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  run request; sampled only in IDLE
- `start_ptr`  in  address_t  first entry to read
- `count`  in  CNT_W  entries to read; 0 = empty run; values >32 clamp to 32
- `read_pointer`  out  address_t  registered address into the instruction register
- `instruction_word`  in  instruction_t  combinational read data from the instruction register
- `out_valid`  out  1  checked entry available
- `out_ready`  in  1  downstream accepts entry
- `out_instr`  out  instruction_t  captured entry
- `out_index`  out  address_t  address the entry came from
- `out_expected`  out  result_t  recomputed result
- `out_mismatch`  out  1  `out_instr.rezultat` != `out_expected`
- `out_div0`  out  1  DIV/MOD with `op_b` == 0; comparison suppressed
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at end of run
- `error_count`  out  CNT_W  mismatches in the current or last run

## Operation
- FSM states: IDLE, FETCH, SEND, DONE.
- **IDLE:** when `start`=1, load `ptr`<=`start_ptr` and `remaining`<=clamp(`count`) and clear `error_count`. Go to FETCH, or to DONE if `count`==0.
- **FETCH:** `read_pointer`=`ptr` is stable, so `instruction_word` is valid this cycle. At the clock edge, register `out_instr`, `out_index`, `out_expected`, `out_mismatch` and `out_div0`, then go to SEND.
- **SEND:** `out_valid`=1. All `out_*` are held stable while `out_ready`=0. On `out_valid`&&`out_ready`:
  - `error_count` += `out_mismatch`.
  - If `remaining`==1, go to DONE.
  - Otherwise `ptr`<=`ptr`+1 (wraps 31→0), `remaining`<=`remaining`-1, go to FETCH.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **Expected result:** operands are sign-extended to result_t (signed 64-bit), arithmetic is signed.
  - ZERO → 0
  - PASSA → a
  - PASSB → b
  - ADD → a+b
  - SUB → a−b
  - MULT → a*b (full 64-bit product)
  - DIV → a/b, truncating toward zero
  - MOD → a%b, sign follows a
  - DIV/MOD with b==0 → expected 0, `out_div0`=1, `out_mismatch`=0.
  - Any opcode encoding outside the enum → expected 0, compared normally.
- `start` while `busy` is ignored, with no effect on the current run.
- `error_count` never exceeds 32, so no saturation logic is needed.

## Timing
- **Reset** (async, any state): state=IDLE. All outputs are 0: `read_pointer`, `out_*`, `out_valid`, `busy`, `done`, `error_count`. A run in progress is abandoned with no `done` pulse.
- **Start at cycle T:**
  - `busy`=1 and `read_pointer`=`start_ptr` from T+1.
  - First `out_valid` at T+2.
- **Throughput:** with `out_ready` held high, one entry per 2 cycles.
  - Entry k handshakes at T+2+2k.
  - `done` is at T+2N+1 for N entries.
- **Empty run** (`count`=0): `done` at T+1, no `out_valid`, `error_count`=0.
- **Back-pressure:** each cycle of `out_ready`=0 in SEND delays the run by one cycle. `read_pointer` stays unchanged during the stall.
- **Back-to-back runs:** the earliest new `start` is accepted in the first IDLE cycle after `done`.
- **Writer activity during a run:** entries are sampled in their FETCH cycle. A write landing at that address on an earlier edge is visible in the capture.

## Structure
- Existing package (`instr_register_pkg`) provides operand_t, opcode_t, address_t, result_t and instruction_t; the block reuses these unchanged.
- Add to the package:
  - the state enum `rbc_state_t`
  - a `count_t` typedef for `CNT_W`
  - a `calc_expected(opcode_t, operand_t, operand_t)` function returning result_t plus a div0 flag, shared with the testbench scoreboard.
- Sub-module `instr_result_model`: combinational wrapper around `calc_expected`, instantiated once in the checker's FETCH datapath.

## Test plan
- **Clean ADD run:** preload entries 0–3 with ADD (5,3,8), SUB (5,3,2), MULT (−4,6,−24), PASSB (x,9,9). Start `start_ptr`=0, `count`=4, `out_ready`=1 → four entries with `out_mismatch`=0, `done` at T+9, `error_count`=0.
- **Injected error:** entry 7 = ADD(10,20) with `rezultat` 31 → `out_mismatch`=1 for `out_index`=7, `error_count`=1.
- **Wrap and clamp:** `start_ptr`=30, `count`=40 → 32 entries, indices 30, 31, 0, … 29, then `done`.
- **Div by zero:** DIV(7,0) and MOD(−7,0) → `out_expected`=0, `out_div0`=1, `out_mismatch`=0. DIV(−7,2) expects −3; MOD(−7,2) expects −1.
- **Back-pressure and ignored start:** hold `out_ready`=0 for 5 cycles on entry 0 → `out_*` and `read_pointer` stable throughout; a `start` pulsed mid-run has no effect.
- **Mid-run reset and empty run:** assert `reset_n`=0 during SEND → all outputs 0 immediately, no `done`. Then `count`=0 → `done` at T+1, no `out_valid`.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side checker, plus the
// reference result calculation used by the checker datapath.
package instr_register_pkg;

    localparam int NUM_ENTRIES = 32;
    localparam int CNT_W       = 6;

    typedef logic signed [31:0] operand_t;
    typedef logic [$clog2(NUM_ENTRIES)-1:0] address_t;
    typedef logic signed [63:0] result_t;
    typedef logic [CNT_W-1:0] count_t;

    typedef enum logic [3:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef struct packed {
        opcode_t  opcode;
        operand_t op_a;
        operand_t op_b;
        result_t  rezultat;
    } instruction_t;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} rbc_state_t;

    typedef struct packed {
        result_t value;
        logic    div0;
    } calc_t;

    // Operands are widened to 64 bits first so MULT keeps the full product.
    function automatic calc_t calc_expected(opcode_t opcode, operand_t op_a, operand_t op_b);
        result_t a;
        result_t b;
        calc_t   r;
        a = {{32{op_a[31]}}, op_a};
        b = {{32{op_b[31]}}, op_b};
        r.value = '0;
        r.div0  = 1'b0;
        case (opcode)
            ZERO:  r.value = '0;
            PASSA: r.value = a;
            PASSB: r.value = b;
            ADD:   r.value = a + b;
            SUB:   r.value = a - b;
            MULT:  r.value = a * b;
            DIV:   if (b == '0) r.div0 = 1'b1; else r.value = a / b;
            MOD:   if (b == '0) r.div0 = 1'b1; else r.value = a % b;
            default: r.value = '0;
        endcase
        return r;
    endfunction

    function automatic count_t clamp_count(count_t c);
        return (c > count_t'(NUM_ENTRIES)) ? count_t'(NUM_ENTRIES) : c;
    endfunction

endpackage

// File: rtl/instr_readback_checker_if.sv
// Downstream valid/ready stream carrying each checked instruction entry.
interface instr_readback_checker_if;
    import instr_register_pkg::*;

    logic         out_valid;
    logic         out_ready;
    instruction_t out_instr;
    address_t     out_index;
    result_t      out_expected;
    logic         out_mismatch;
    logic         out_div0;

    modport master (
        output out_valid, out_instr, out_index, out_expected, out_mismatch, out_div0,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_instr, out_index, out_expected, out_mismatch, out_div0,
        output out_ready
    );

endinterface

// File: rtl/instr_result_model.sv
// Combinational expected-result calculator for one instruction entry.
module instr_result_model
    import instr_register_pkg::*;
(
    input  opcode_t  opcode,
    input  operand_t op_a,
    input  operand_t op_b,
    output result_t  expected,
    output logic     div0
);

    calc_t calc;

    assign calc     = calc_expected(opcode, op_a, op_b);
    assign expected = calc.value;
    assign div0     = calc.div0;

endmodule

// File: rtl/instr_readback_checker.sv
// Walks a window of the instruction register, recomputes each result and streams
// the checked entries downstream while counting mismatches for the run.
module instr_readback_checker
    import instr_register_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  address_t                  start_ptr,
    input  count_t                    count,
    output address_t                  read_pointer,
    input  instruction_t              instruction_word,
    instr_readback_checker_if.master  out_if,
    output logic                      busy,
    output logic                      done,
    output count_t                    error_count
);

    rbc_state_t state_reg;
    count_t     remaining_reg;
    result_t    calc_value;
    logic       calc_div0;

    instr_result_model u_result_model (
        .opcode   (instruction_word.opcode),
        .op_a     (instruction_word.op_a),
        .op_b     (instruction_word.op_b),
        .expected (calc_value),
        .div0     (calc_div0)
    );

    // read_pointer doubles as the walk pointer, so it cannot move during a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg           <= IDLE;
            remaining_reg       <= '0;
            read_pointer        <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error_count         <= '0;
            out_if.out_valid    <= 1'b0;
            out_if.out_instr    <= '0;
            out_if.out_index    <= '0;
            out_if.out_expected <= '0;
            out_if.out_mismatch <= 1'b0;
            out_if.out_div0     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        read_pointer  <= start_ptr;
                        remaining_reg <= clamp_count(count);
                        error_count   <= '0;
                        busy          <= 1'b1;
                        if (count == '0) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    out_if.out_instr    <= instruction_word;
                    out_if.out_index    <= read_pointer;
                    out_if.out_expected <= calc_value;
                    out_if.out_div0     <= calc_div0;
                    out_if.out_mismatch <= !calc_div0 && (instruction_word.rezultat != calc_value);
                    out_if.out_valid    <= 1'b1;
                    state_reg           <= SEND;
                end
                SEND: begin
                    if (out_if.out_ready) begin
                        out_if.out_valid <= 1'b0;
                        error_count      <= error_count + count_t'(out_if.out_mismatch);
                        if (remaining_reg == count_t'(1)) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            read_pointer  <= read_pointer + address_t'(1);
                            remaining_reg <= remaining_reg - count_t'(1);
                            state_reg     <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_readback_checker.sv
// Self-checking bench: hand-computed vector table, directed corner sequences and
// randomized runs scored against an arithmetic reference model.
module tb_instr_readback_checker;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    address_t     start_ptr = '0;
    count_t       count = '0;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         busy;
    logic         done;
    count_t       error_count;

    instruction_t mem [NUM_ENTRIES];
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;

    instr_readback_checker_if out_if ();

    instr_readback_checker dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_ptr        (start_ptr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .out_if           (out_if),
        .busy             (busy),
        .done             (done),
        .error_count      (error_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign instruction_word = mem[read_pointer];

    typedef struct {
        logic [3:0] op;
        int         a;
        int         b;
        longint     rez;
        longint     e;
        bit         mis;
        bit         d0;
    } vec_t;

    localparam int NV = 15;
    vec_t tab [NV];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_instr(input string name, input instruction_t act, input instruction_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the result rules, on 64-bit integers.
    function automatic void ref_model(input logic [3:0] op, input int a, input int b,
                                      output longint e, output bit d0);
        longint la = a;
        longint lb = b;
        e = 0;
        d0 = 0;
        case (op)
            4'd1: e = la;
            4'd2: e = lb;
            4'd3: e = la + lb;
            4'd4: e = la - lb;
            4'd5: e = la * lb;
            4'd6: if (lb == 0) d0 = 1; else e = la / lb;
            4'd7: if (lb == 0) d0 = 1; else e = la % lb;
            default: e = 0;
        endcase
    endfunction

    function automatic instruction_t mk(input logic [3:0] op, input int a, input int b, input longint rez);
        instruction_t t;
        t.opcode   = opcode_t'(op);
        t.op_a     = a;
        t.op_b     = b;
        t.rezultat = rez;
        return t;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            logic [3:0] op;
            int a, b;
            longint e;
            bit d0;
            op = 4'($urandom_range(0, 9));
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) - 10 : int'($urandom);
            b  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom);
            ref_model(op, a, b, e, d0);
            mem[i] = mk(op, a, b, ($urandom_range(0, 3) == 0) ? e + 1 : e);
        end
    endtask

    // Start a run, accept entries with the given ready probability and score them.
    task automatic do_run(input int sp, input int cnt, input int ready_pct,
                          input bit timing, input bit use_tab, input string tag);
        int n, k, t0, exp_err, idx;
        bit finished, rdy, d0, mis;
        longint e;
        n = (cnt > NUM_ENTRIES) ? NUM_ENTRIES : cnt;
        k = 0;
        exp_err = 0;
        finished = 0;
        @(negedge clk);
        t0 = cyc;
        start = 1'b1;
        start_ptr = address_t'(sp);
        count = count_t'(cnt);
        @(negedge clk);
        start = 1'b0;
        if (timing) begin
            chk({tag, " busy"}, busy, 1);
            if (n > 0) chk({tag, " read_pointer"}, read_pointer, sp % NUM_ENTRIES);
        end
        for (int c = 0; c < 3000 && !finished; c++) begin
            if (done) begin
                chk({tag, " entries"}, k, n);
                chk({tag, " error_count"}, error_count, exp_err);
                if (timing) chk({tag, " done_cycle"}, cyc - t0, 2 * n + 1);
                finished = 1;
            end else begin
                rdy = ($urandom_range(0, 99) < ready_pct);
                out_if.out_ready = rdy;
                if (out_if.out_valid && k >= n) chk({tag, " extra_valid"}, 1, 0);
                if (out_if.out_valid && rdy && k < n) begin
                    idx = (sp + k) % NUM_ENTRIES;
                    if (use_tab) begin
                        e = tab[k].e; d0 = tab[k].d0; mis = tab[k].mis;
                    end else begin
                        ref_model(mem[idx].opcode, mem[idx].op_a, mem[idx].op_b, e, d0);
                        mis = !d0 && (mem[idx].rezultat != e);
                    end
                    chk($sformatf("%s idx[%0d]", tag, k), out_if.out_index, idx);
                    chk_instr($sformatf("%s instr[%0d]", tag, k), out_if.out_instr, mem[idx]);
                    chk($sformatf("%s expected[%0d]", tag, k), out_if.out_expected, e);
                    chk($sformatf("%s mismatch[%0d]", tag, k), out_if.out_mismatch, mis);
                    chk($sformatf("%s div0[%0d]", tag, k), out_if.out_div0, d0);
                    if (timing && ready_pct >= 100)
                        chk($sformatf("%s hs_cycle[%0d]", tag, k), cyc - t0, 2 + 2 * k);
                    if (mis) exp_err++;
                    k++;
                end
                @(negedge clk);
            end
        end
        if (!finished) chk({tag, " timeout"}, 0, 1);
        $display("run %s: start_ptr=%0d count=%0d entries=%0d error_count=%0d", tag, sp, cnt, k, error_count);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, done, 0);
        chk({tag, " idle_after"}, busy, 0);
    endtask

    initial begin
        int w;
        instruction_t snap;
        longint e;
        bit d0;

        tab[0]  = '{4'd3, 5, 3, 8, 8, 0, 0};
        tab[1]  = '{4'd4, 5, 3, 2, 2, 0, 0};
        tab[2]  = '{4'd5, -4, 6, -24, -24, 0, 0};
        tab[3]  = '{4'd2, 77, 9, 9, 9, 0, 0};
        tab[4]  = '{4'd6, 7, 0, 123, 0, 0, 1};
        tab[5]  = '{4'd7, -7, 0, 5, 0, 0, 1};
        tab[6]  = '{4'd6, -7, 2, -3, -3, 0, 0};
        tab[7]  = '{4'd3, 10, 20, 31, 30, 1, 0};
        tab[8]  = '{4'd7, -7, 2, -1, -1, 0, 0};
        tab[9]  = '{4'd0, 99, 1, 0, 0, 0, 0};
        tab[10] = '{4'd1, -5, 8, -5, -5, 0, 0};
        tab[11] = '{4'd11, 1, 2, 3, 0, 1, 0};
        tab[12] = '{4'd5, 32'h7fffffff, 2, 64'd4294967294, 64'd4294967294, 0, 0};
        tab[13] = '{4'd4, 32'h80000000, 1, -64'sd2147483649, -64'sd2147483649, 0, 0};
        tab[14] = '{4'd6, 100, -7, -14, -14, 0, 0};

        out_if.out_ready = 1'b1;
        for (int i = 0; i < NUM_ENTRIES; i++) mem[i] = '0;

        #2 reset_n = 1'b0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset out_valid", out_if.out_valid, 0);
        chk("reset read_pointer", read_pointer, 0);
        chk("reset error_count", error_count, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) mem[i] = mk(tab[i].op, tab[i].a, tab[i].b, tab[i].rez);
        do_run(0, 4, 100, 1, 1, "clean");
        do_run(0, NV, 100, 1, 1, "table");

        fill_random();
        do_run(30, 40, 100, 1, 0, "wrap_clamp");

        // Back-pressure on the first entry with a stray start mid-stall.
        fill_random();
        out_if.out_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; start_ptr = '0; count = count_t'(2);
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!out_if.out_valid && w < 10) begin @(negedge clk); w++; end
        chk("bp valid_seen", out_if.out_valid, 1);
        snap = out_if.out_instr;
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            start_ptr = address_t'(17);
            count = count_t'(5);
            chk("bp valid_hold", out_if.out_valid, 1);
            chk("bp index_hold", out_if.out_index, 0);
            chk("bp rdptr_hold", read_pointer, 0);
            chk_instr("bp instr_hold", out_if.out_instr, snap);
            @(negedge clk);
        end
        start = 1'b0;
        chk_instr("bp instr_entry0", snap, mem[0]);
        out_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp rdptr_next", read_pointer, 1);
        @(negedge clk);
        chk("bp index_next", out_if.out_index, 1);
        ref_model(mem[1].opcode, mem[1].op_a, mem[1].op_b, e, d0);
        chk("bp expected_next", out_if.out_expected, e);
        @(negedge clk);
        chk("bp done", done, 1);
        $display("run backpressure: stalled 5 cycles, stray start ignored, done=%0d", done);
        @(negedge clk);
        chk("bp idle", busy, 0);

        // Reset while an entry is waiting in SEND.
        out_if.out_ready = 1'b0;
        start = 1'b1; start_ptr = address_t'(5); count = count_t'(3);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst valid_before", out_if.out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("rst out_valid", out_if.out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst read_pointer", read_pointer, 0);
        chk("rst out_index", out_if.out_index, 0);
        chk("rst out_expected", out_if.out_expected, 0);
        chk_instr("rst out_instr", out_if.out_instr, '0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("rst no_done", done, 0);
            chk("rst stays_idle", busy, 0);
            @(negedge clk);
        end
        $display("run midreset: outputs cleared, no done pulse");
        out_if.out_ready = 1'b1;
        do_run(9, 0, 100, 1, 0, "empty");

        for (int r = 0; r < 12; r++) begin
            fill_random();
            do_run(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), 60, 0, 0,
                   $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
